// File: rtl/fpu_pkg.sv
// Shared binary32 definitions for the basic FPU path.
//   - field widths and bit offsets of an IEEE-754 single
//   - canonical quiet NaN reported when a frame holds no ordered sample
//   - NaN classifier and the range-tracker state encoding
package fpu_pkg;

    localparam int FP_W        = 32;
    localparam int FP_EXP_W    = 8;
    localparam int FP_MAN_W    = 23;
    localparam int FP_MAN_LSB  = 0;
    localparam int FP_EXP_LSB  = FP_MAN_LSB + FP_MAN_W;
    localparam int FP_SIGN_BIT = FP_EXP_LSB + FP_EXP_W;

    localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        RESULT = 2'd2
    } state_t;

    function automatic logic is_nan(input logic [FP_W-1:0] x);
        return (x[FP_EXP_LSB +: FP_EXP_W] == {FP_EXP_W{1'b1}}) &&
               (x[FP_MAN_LSB +: FP_MAN_W] != '0);
    endfunction

endpackage

// File: rtl/float_minmax_stream_if.sv
// Sample stream in (valid/ready/last) and result beat out (valid/ready).
//   master : upstream producer / downstream consumer side
//   slave  : float_minmax_stream side
interface float_minmax_stream_if #(
    parameter int COUNT_W = 16
);
    logic [31:0]        s_data;
    logic               s_valid;
    logic               s_last;
    logic               s_ready;
    logic [31:0]        m_max;
    logic [31:0]        m_min;
    logic [COUNT_W-1:0] m_count;
    logic               m_nan;
    logic               m_valid;
    logic               m_ready;

    modport master (
        output s_data, s_valid, s_last, m_ready,
        input  s_ready, m_max, m_min, m_count, m_nan, m_valid
    );

    modport slave (
        input  s_data, s_valid, s_last, m_ready,
        output s_ready, m_max, m_min, m_count, m_nan, m_valid
    );

endinterface

// File: rtl/float_greater_than.sv
// Combinational binary32 ordering: o_gt = (i_a > i_b).
//   i_a, i_b : binary32 operands
//   o_gt     : strict greater-than; 0 if either operand is NaN
// Infinities order normally and -0 orders strictly below +0.
module float_greater_than
    import fpu_pkg::*;
(
    input  logic [FP_W-1:0] i_a,
    input  logic [FP_W-1:0] i_b,
    output logic            o_gt
);

    logic [FP_W-1:0] w_key_a;
    logic [FP_W-1:0] w_key_b;

    // Map onto an unsigned key whose order matches numeric order:
    // negatives are bit-inverted, positives get the top bit set.
    // -0 becomes 7FFFFFFF and +0 becomes 80000000, so they stay distinct.
    assign w_key_a = i_a[FP_SIGN_BIT] ? ~i_a : {1'b1, i_a[FP_SIGN_BIT-1:0]};
    assign w_key_b = i_b[FP_SIGN_BIT] ? ~i_b : {1'b1, i_b[FP_SIGN_BIT-1:0]};

    assign o_gt = !is_nan(i_a) && !is_nan(i_b) && (w_key_a > w_key_b);

endmodule

// File: rtl/float_minmax_stream.sv
// Streaming binary32 range tracker: running max/min, sample count and
// NaN presence per frame, one result beat at end-of-frame.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : sample stream in, result beat out (slave modport)
//
// state  | meaning
// IDLE   | no ordered (non-NaN) sample held yet in this frame
// ACCUM  | max/min hold valid data
// RESULT | result beat presented, input stalled
module float_minmax_stream
    import fpu_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    float_minmax_stream_if.slave  bus
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [FP_W-1:0]    r_max;
    logic [FP_W-1:0]    r_min;
    logic [COUNT_W-1:0] r_count;
    logic               r_nan;

    logic               w_accept;
    logic               w_done;
    logic               w_sample_nan;
    logic               w_gt_max;
    logic               w_lt_min;

    assign w_accept     = bus.s_valid && (r_state != RESULT);
    assign w_done       = (r_state == RESULT) && bus.m_ready;
    assign w_sample_nan = is_nan(bus.s_data);

    float_greater_than u_gt_max (
        .i_a  (bus.s_data),
        .i_b  (r_max),
        .o_gt (w_gt_max)
    );

    float_greater_than u_gt_min (
        .i_a  (r_min),
        .i_b  (bus.s_data),
        .o_gt (w_lt_min)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (bus.s_last) begin
                        w_state_nxt = RESULT;
                    end else if (!w_sample_nan) begin
                        w_state_nxt = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (w_accept && bus.s_last) begin
                    w_state_nxt = RESULT;
                end
            end
            RESULT: begin
                if (bus.m_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // In IDLE a NaN parks the canonical QNaN in max/min so an all-NaN
    // frame reports it; the first ordered sample overwrites it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_max   <= '0;
            r_min   <= '0;
            r_count <= '0;
            r_nan   <= 1'b0;
        end else if (w_done) begin
            r_max   <= '0;
            r_min   <= '0;
            r_count <= '0;
            r_nan   <= 1'b0;
        end else if (w_accept) begin
            if (r_count != {COUNT_W{1'b1}}) begin
                r_count <= r_count + 1'b1;
            end
            if (w_sample_nan) begin
                r_nan <= 1'b1;
                if (r_state == IDLE) begin
                    r_max <= FP_QNAN;
                    r_min <= FP_QNAN;
                end
            end else if (r_state == IDLE) begin
                r_max <= bus.s_data;
                r_min <= bus.s_data;
            end else begin
                if (w_gt_max) begin
                    r_max <= bus.s_data;
                end
                if (w_lt_min) begin
                    r_min <= bus.s_data;
                end
            end
        end
    end

    assign bus.s_ready = (r_state != RESULT);
    assign bus.m_valid = (r_state == RESULT);
    assign bus.m_max   = r_max;
    assign bus.m_min   = r_min;
    assign bus.m_count = r_count;
    assign bus.m_nan   = r_nan;

endmodule

// File: tb/tb_float_minmax_stream.sv
module tb_float_minmax_stream;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    float_minmax_stream_if #(.COUNT_W(16)) bus ();
    float_minmax_stream_if #(.COUNT_W(2))  bus2 ();

    // Second instance with a tiny counter sees the identical stream.
    assign bus2.s_data  = bus.s_data;
    assign bus2.s_valid = bus.s_valid;
    assign bus2.s_last  = bus.s_last;
    assign bus2.m_ready = bus.m_ready;

    float_minmax_stream #(.COUNT_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    float_minmax_stream #(.COUNT_W(2)) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] frame_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Numeric a > b for non-NaN binary32: sign first (+0 above -0),
    // then bit-pattern magnitude, reversed for negatives.
    function automatic bit ref_gt(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31]) return b[31];
        if (!a[31]) return a[30:0] > b[30:0];
        return a[30:0] < b[30:0];
    endfunction

    function automatic bit ref_nan(input logic [31:0] a);
        return (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    endfunction

    function automatic logic [31:0] gen_sample();
        logic [31:0] pool [4];
        logic        s;
        pool[0] = 32'h3F80_0000;
        pool[1] = 32'hBF80_0000;
        pool[2] = 32'h4120_0000;
        pool[3] = 32'h0000_0001;
        s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 7))
            0: return $urandom;
            1: return {s, 8'hFF, 23'($urandom_range(1, 32'h7F_FFFF))};
            2: return {s, 31'd0};
            3: return {s, 8'hFF, 23'd0};
            4: return pool[$urandom_range(0, 3)];
            default: return {s, 8'(120 + $urandom_range(0, 14)), 23'($urandom)};
        endcase
    endfunction

    task automatic check_outs(input string tag, input logic [31:0] mx, input logic [31:0] mn,
                              input int n, input bit nan, input bit valid);
        chk({tag, "_valid"},   32'(bus.m_valid), 32'(valid));
        chk({tag, "_s_ready"}, 32'(bus.s_ready), 32'(!valid));
        chk({tag, "_max"},     bus.m_max, mx);
        chk({tag, "_min"},     bus.m_min, mn);
        chk({tag, "_count"},   32'(bus.m_count), 32'((n > 65535) ? 65535 : n));
        chk({tag, "_nan"},     32'(bus.m_nan), 32'(nan));
        chk({tag, "_count_w2"}, 32'(bus2.m_count), 32'((n > 3) ? 3 : n));
        chk({tag, "_max_w2"},  bus2.m_max, mx);
    endtask

    task automatic drive_sample(input logic [31:0] d, input bit last, input int gap);
        int waited;
        waited = 0;
        repeat (gap) begin
            @(negedge clk);
            bus.s_valid = 1'b0;
            bus.s_data  = $urandom;
            bus.s_last  = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        chk("busy_m_valid", 32'(bus.m_valid), 32'd0);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        while (!bus.s_ready) begin
            if (waited > 20) begin
                chk("accept_timeout", 32'(bus.s_ready), 32'd1);
                return;
            end
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
    endtask

    task automatic run_frame(input int hold, input bit b2b);
        logic [31:0] e_max;
        logic [31:0] e_min;
        bit          e_nan;
        bit          have;
        int          n;
        e_max = QNAN;
        e_min = QNAN;
        e_nan = 1'b0;
        have  = 1'b0;
        n     = frame_q.size();
        foreach (frame_q[i]) begin
            if (ref_nan(frame_q[i])) begin
                e_nan = 1'b1;
            end else if (!have) begin
                have  = 1'b1;
                e_max = frame_q[i];
                e_min = frame_q[i];
            end else begin
                if (ref_gt(frame_q[i], e_max)) e_max = frame_q[i];
                if (ref_gt(e_min, frame_q[i])) e_min = frame_q[i];
            end
        end
        for (int i = 0; i < n; i++) begin
            drive_sample(frame_q[i], i == n - 1, b2b ? 0 : int'($urandom_range(0, 2)));
        end
        @(negedge clk);
        check_outs("res", e_max, e_min, n, e_nan, 1'b1);
        for (int h = 0; h < hold; h++) begin
            bus.m_ready = 1'b0;
            bus.s_valid = 1'b1;
            bus.s_data  = $urandom;
            bus.s_last  = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_outs("hold", e_max, e_min, n, e_nan, 1'b1);
        end
        bus.m_ready = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = $urandom;
        @(negedge clk);
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b0;
        check_outs("clr", 32'd0, 32'd0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n     = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 32'd0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_outs("rst", 32'd0, 32'd0, 0, 1'b0, 1'b0);
        reset_n = 1'b1;

        frame_q = '{32'h3F40_0000, 32'h3E80_0000, 32'hBF00_0000};
        run_frame(0, 1'b1);
        frame_q = '{32'h4290_6733, 32'h4290_6799, 32'hC290_6799};
        run_frame(1, 1'b1);
        frame_q = '{32'h8000_0000, 32'h0000_0000};
        run_frame(0, 1'b1);
        frame_q = '{32'h7FC0_0001, 32'h3E80_0000, 32'h7F80_0001};
        run_frame(0, 1'b1);
        frame_q = '{32'h7FC0_0000};
        run_frame(0, 1'b1);
        frame_q = '{32'h3F40_0000, 32'h3E80_0000, 32'hBF00_0000};
        run_frame(5, 1'b1);
        frame_q = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'hC000_0000, 32'h3F00_0000};
        run_frame(2, 1'b0);

        // Reset part-way through a frame discards everything held.
        drive_sample(32'h3F80_0000, 1'b0, 0);
        drive_sample(32'hC120_0000, 1'b0, 0);
        @(negedge clk);
        reset_n     = 1'b0;
        bus.s_valid = 1'b0;
        #1;
        check_outs("rst_mid", 32'd0, 32'd0, 0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        frame_q = '{32'h3E80_0000};
        run_frame(0, 1'b1);

        // Reset while a result is presented.
        drive_sample(32'h40A0_0000, 1'b0, 0);
        drive_sample(32'hC0A0_0000, 1'b1, 0);
        @(negedge clk);
        chk("pre_rst_valid", 32'(bus.m_valid), 32'd1);
        reset_n     = 1'b0;
        bus.s_valid = 1'b0;
        #1;
        check_outs("rst_res", 32'd0, 32'd0, 0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        frame_q.delete();
        for (int i = 0; i < 20; i++) frame_q.push_back(gen_sample());
        run_frame(1, 1'b1);

        for (int f = 0; f < 60; f++) begin
            frame_q.delete();
            for (int i = 0; i < int'($urandom_range(1, 6)); i++) frame_q.push_back(gen_sample());
            run_frame(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/float_minmax_stream.md
# float_minmax_stream

Streaming single-precision range tracker that sits directly downstream of the combinational `float_greater_than` comparator in the basic FPU path. It accepts a framed stream of IEEE-754 binary32 samples over a valid/ready handshake and tracks the running maximum, minimum, sample count and NaN presence. At end-of-frame it presents one result beat on an output valid/ready handshake. Two comparator instances make the ordering decisions; this block supplies the sequencing, state and buffering around them.

## Interface
- `COUNT_W`, 16, width of the per-frame sample counter (saturating)
- `clk`  in  1  single system clock, all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `s_data`  in  32  binary32 sample
- `s_valid`  in  1  sample present
- `s_last`  in  1  sample is final in frame; qualified by `s_valid`
- `s_ready`  out  1  block can accept a sample this cycle
- `m_max`  out  32  largest non-NaN sample of the frame
- `m_min`  out  32  smallest non-NaN sample of the frame
- `m_count`  out  COUNT_W  samples accepted in the frame, NaNs included
- `m_nan`  out  1  at least one NaN seen in the frame
- `m_valid`  out  1  result beat valid
- `m_ready`  in  1  downstream accepts result

## Operation
- Accept occurs when `s_valid && s_ready` on a rising edge.
- FSM states: IDLE (no non-NaN sample held), ACCUM (max/min hold valid data), RESULT (result presented).
- IDLE: accepted non-NaN sample loads max and min, count=1, go to ACCUM. Accepted NaN sets nan flag, count=1, stay IDLE. If `s_last` is set on either, go to RESULT.
- ACCUM: accepted non-NaN sample replaces max if `float_greater_than(sample, max)`, replaces min if `float_greater_than(min, sample)`. Ties keep the held value. NaN sets the flag only. `s_last` moves to RESULT.
- RESULT: `s_ready`=0, `m_valid`=1. Outputs are stable until `m_ready`. On `m_valid && m_ready`, clear count, flag and held values, go to IDLE.
- NaN is exponent 8'hFF with mantissa ≠ 0. Infinities are ordered normally.
- Signed zero: -0 orders strictly below +0.
- Frame of only NaNs: `m_max`=`m_min`=32'h7FC00000, `m_nan`=1.
- Count saturates at all-ones. It never wraps.
- `s_ready` = (state != RESULT). It is driven from the registered state only and has no combinational path from `m_ready`.

## Timing
- Reset, asynchronous: state IDLE, `m_valid`=0, `m_max`=`m_min`=0, `m_count`=0, `m_nan`=0. `s_ready`=1 once reset releases.
- Reset mid-frame or mid-RESULT discards all held data. There is no partial result.
- Update latency is one cycle. A sample accepted at edge N is reflected in the held max/min at N+1.
- A last sample accepted at edge N gives `m_valid`=1 from N+1.
- Result handshake at edge M gives `s_ready`=1 from M+1. There is one bubble between frames.
- Back-to-back accepts every cycle are sustained within a frame.
- `s_valid` with `s_ready`=0 is not accepted. Upstream holds its data.
- `s_last` on the first sample gives a single-sample frame with max=min=sample and count=1.

## Structure
- Shared package `fpu_pkg`:
  - binary32 field widths and offsets
  - `FP_QNAN` = 32'h7FC00000
  - `is_nan` function
  - state enum {IDLE, ACCUM, RESULT}
- Sub-module: the existing `float_greater_than`, instantiated twice (sample vs max, min vs sample). No other sub-modules.
- One FSM process, one datapath register process, combinational output assigns.

## Test plan
- Frame 3F400000, 3E800000, BF000000 (last); `m_ready`=1 → `m_max`=3F400000, `m_min`=BF000000, `m_count`=3, `m_nan`=0, `m_valid` one cycle after last accept.
- Frame 42906733, 42906799, C2906799 (last) → `m_max`=42906799, `m_min`=C2906799, `m_count`=3.
- Frame 80000000, 00000000 (last) → `m_max`=00000000, `m_min`=80000000.
- Frame 7FC00001, 3E800000, 7F800001 (last) → `m_max`=`m_min`=3E800000, `m_count`=3, `m_nan`=1. Second frame of only 7FC00000 → `m_max`=`m_min`=7FC00000, `m_nan`=1.
- Hold `m_ready`=0 for 5 cycles with `s_valid`=1 → `s_ready`=0 and outputs stable throughout. `m_ready`=1 → `s_ready`=1 on the next cycle. Next frame unaffected.
- Assert `reset_n`=0 mid-frame after 2 samples, release, send 3E800000 (last) → `m_count`=1, `m_max`=`m_min`=3E800000. COUNT_W=2 with 5 samples → `m_count`=3.
